// File: rtl/axi_mem_slave.sv
// axi_mem_slave
// AXI4 memory subordinate backed by a single-ported word array. It handles one
// transaction at a time. Bursts are always treated as INCR, from 1 to 256 beats.
// Writes honour the per-byte strobes. Beats that fall outside the array, or a
// transfer size that differs from the bus width, produce SLVERR.
//
// Ports
//   clk, reset_n               clock (rising edge) and synchronous active-low reset
//   s_axi_aw*                  write address channel (awburst is ignored)
//   s_axi_w*                   write data channel
//   s_axi_b*                   write response channel
//   s_axi_ar*                  read address channel (arburst is ignored)
//   s_axi_r*                   read data channel
//   busy                       high while a transaction is in progress
module axi_mem_slave #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int MEM_DEPTH_WORDS    = 1024
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic [2:0]                      s_axi_awsize,
    input  logic [1:0]                      s_axi_awburst,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    input  logic [2:0]                      s_axi_arsize,
    input  logic [1:0]                      s_axi_arburst,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rlast,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            busy
);
    localparam int BYTES = C_S_AXI_DATA_WIDTH / 8;
    localparam int LOG2B = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WRITE_DATA = 2'd1,
        S_WRITE_RESP = 2'd2,
        S_READ_DATA  = 2'd3
    } state_e;

    state_e                          state_q, state_d;
    logic [C_S_AXI_ID_WIDTH-1:0]     id_q, id_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                      len_q, len_d;
    logic [8:0]                      cnt_q, cnt_d;
    logic                            err_q, err_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]   mem_q [MEM_DEPTH_WORDS];

    logic aw_hs_s, ar_hs_s, w_hs_s, b_hs_s, r_hs_s;
    logic in_range_s, past_len_s, wr_en_s;
    logic [IDX_W-1:0] idx_s;
    logic unused_s;

    // The burst type is not decoded; every burst is incrementing.
    assign unused_s = ^{s_axi_awburst, s_axi_arburst};

    // The ready signals are gated by reset_n so that nothing is accepted while reset is held.
    assign s_axi_awready = reset_n && (state_q == S_IDLE);
    assign s_axi_arready = reset_n && (state_q == S_IDLE) && !s_axi_awvalid;
    assign s_axi_wready  = reset_n && (state_q == S_WRITE_DATA);
    assign busy          = (state_q != S_IDLE);

    assign aw_hs_s    = s_axi_awvalid && s_axi_awready;
    assign ar_hs_s    = s_axi_arvalid && s_axi_arready;
    assign w_hs_s     = s_axi_wvalid && s_axi_wready;
    assign b_hs_s     = s_axi_bvalid && s_axi_bready;
    assign r_hs_s     = s_axi_rvalid && s_axi_rready;
    assign in_range_s = (addr_q < C_S_AXI_ADDR_WIDTH'(MEM_DEPTH_WORDS));
    assign past_len_s = (cnt_q > {1'b0, len_q});
    assign idx_s      = addr_q[IDX_W-1:0];
    // A beat is written only if no error has been seen so far, the beat is inside the array,
    // and the beat is not an excess beat after the announced burst length.
    assign wr_en_s    = w_hs_s && !err_q && in_range_s && !past_len_s;

    // Response channels are driven from the latched transaction and are zero when not valid.
    assign s_axi_bvalid = (state_q == S_WRITE_RESP);
    assign s_axi_bid    = s_axi_bvalid ? id_q : {C_S_AXI_ID_WIDTH{1'b0}};
    assign s_axi_bresp  = (s_axi_bvalid && err_q) ? 2'b10 : 2'b00;
    assign s_axi_rvalid = (state_q == S_READ_DATA);
    assign s_axi_rid    = s_axi_rvalid ? id_q : {C_S_AXI_ID_WIDTH{1'b0}};
    assign s_axi_rdata  = (s_axi_rvalid && in_range_s) ? mem_q[idx_s] : {C_S_AXI_DATA_WIDTH{1'b0}};
    assign s_axi_rresp  = (s_axi_rvalid && (err_q || !in_range_s)) ? 2'b10 : 2'b00;
    assign s_axi_rlast  = s_axi_rvalid && (cnt_q == {1'b0, len_q});

    // Next-state logic: latch the transaction on an address handshake and advance once per data beat.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (aw_hs_s) begin
                    id_d    = s_axi_awid;
                    addr_d  = s_axi_awaddr >> LOG2B;
                    len_d   = s_axi_awlen;
                    cnt_d   = 9'd0;
                    err_d   = (s_axi_awsize != 3'(LOG2B));
                    state_d = S_WRITE_DATA;
                end else if (ar_hs_s) begin
                    id_d    = s_axi_arid;
                    addr_d  = s_axi_araddr >> LOG2B;
                    len_d   = s_axi_arlen;
                    cnt_d   = 9'd0;
                    err_d   = (s_axi_arsize != 3'(LOG2B));
                    state_d = S_READ_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE_DATA: begin
                if (w_hs_s) begin
                    addr_d = addr_q + C_S_AXI_ADDR_WIDTH'(1);
                    cnt_d  = cnt_q + 9'd1;
                    // Errors are sticky: an out-of-range beat, an excess beat, or a wlast that arrives early.
                    err_d  = err_q || !in_range_s || past_len_s ||
                             (s_axi_wlast && (cnt_q < {1'b0, len_q}));
                    if (s_axi_wlast) begin
                        state_d = S_WRITE_RESP;
                    end else begin
                        state_d = S_WRITE_DATA;
                    end
                end else begin
                    state_d = S_WRITE_DATA;
                end
            end
            S_WRITE_RESP: begin
                if (b_hs_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WRITE_RESP;
                end
            end
            S_READ_DATA: begin
                if (r_hs_s) begin
                    addr_d = addr_q + C_S_AXI_ADDR_WIDTH'(1);
                    cnt_d  = cnt_q + 9'd1;
                    if (s_axi_rlast) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_READ_DATA;
                    end
                end else begin
                    state_d = S_READ_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and transaction registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            id_q    <= {C_S_AXI_ID_WIDTH{1'b0}};
            addr_q  <= {C_S_AXI_ADDR_WIDTH{1'b0}};
            len_q   <= 8'd0;
            cnt_q   <= 9'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Byte-lane write port. The array contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[idx_s][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_axi_awid, s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bid, s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arid, s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_rid, s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    logic [31:0] model [DEPTH];
    rexp_t       rq[$];
    logic [1:0]  bq[$];

    always #5 clk = ~clk;

    axi_mem_slave dut (
        .clk(clk), .reset_n(reset_n),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .busy(busy)
    );

    // Queue the expected read beats using the reference memory as it is when the read is issued.
    task automatic push_read_exp(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
        rexp_t e;
        logic [31:0] word;
        for (int i = 0; i <= int'(len); i++) begin
            word   = (addr >> 2) + 32'(i);
            e.data = (word < DEPTH) ? model[word[9:0]] : 32'h0;
            e.resp = ((size != 3'd2) || (word >= DEPTH)) ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            rq.push_back(e);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [31:0] base, input logic [3:0] strb, input logic id);
        logic        err;
        logic [31:0] word;
        logic [1:0]  eb;
        bit          ok;
        err = (size != 3'd2);
        @(posedge clk); #1;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
        s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (s_axi_awready) ok = 1'b1;
            @(posedge clk); #1;
        end
        s_axi_awvalid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL aw_timeout got awready=0 want 1"); end
        for (int i = 0; i <= int'(len); i++) begin
            word = (addr >> 2) + 32'(i);
            s_axi_wvalid = 1'b1; s_axi_wdata = base + 32'(i); s_axi_wstrb = strb;
            s_axi_wlast = (i == int'(len));
            ok = 1'b0;
            for (int c = 0; c < 50 && !ok; c++) begin
                @(negedge clk);
                if (s_axi_wready) ok = 1'b1;
                @(posedge clk); #1;
            end
            if (!ok) begin checks++; errors++; $display("FAIL w_timeout got wready=0 want 1"); end
            if (!err && word < DEPTH) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model[word[9:0]][8*b +: 8] = s_axi_wdata[8*b +: 8];
                end
            end else begin
                err = 1'b1;
            end
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        bq.push_back(err ? 2'b10 : 2'b00);
        s_axi_bready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (s_axi_bvalid) begin
                ok = 1'b1;
                eb = bq.pop_front();
                checks++;
                if (c != 0) begin errors++; $display("FAIL b_latency got %0d cycles want 0", c); end
                checks++;
                if (s_axi_bresp !== eb || s_axi_bid !== id) begin
                    errors++;
                    $display("FAIL bresp got resp=%b id=%b want resp=%b id=%b", s_axi_bresp, s_axi_bid, eb, id);
                end
            end
            @(posedge clk); #1;
        end
        s_axi_bready = 1'b0;
        if (!ok) begin checks++; errors++; $display("FAIL b_timeout got bvalid=0 want 1"); end
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size, input logic id);
        bit ok;
        @(posedge clk); #1;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size;
        s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (s_axi_arready) ok = 1'b1;
            @(posedge clk); #1;
        end
        s_axi_arvalid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL ar_timeout got arready=0 want 1"); end
    endtask

    // Pop the scoreboard on each R handshake; when rready is low, the held beat must stay unchanged.
    task automatic collect_r(input logic id, input int nbeats, input bit toggle);
        int          got = 0;
        int          cyc = 0;
        bit          held = 1'b0;
        logic [31:0] hd;
        logic [1:0]  hr;
        logic        hl;
        rexp_t       e;
        while (got < nbeats && cyc < 600) begin
            s_axi_rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (s_axi_rvalid !== 1'b1) begin errors++; $display("FAIL r_latency got rvalid=%b want 1", s_axi_rvalid); end
            end
            if (held) begin
                checks++;
                held = 1'b0;
                if (s_axi_rdata !== hd || s_axi_rresp !== hr || s_axi_rlast !== hl) begin
                    errors++;
                    $display("FAIL r_hold got %h/%b/%b want %h/%b/%b", s_axi_rdata, s_axi_rresp, s_axi_rlast, hd, hr, hl);
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++; $display("FAIL r_extra got beat %h want none", s_axi_rdata);
                end else begin
                    e = rq.pop_front();
                    if (s_axi_rdata !== e.data || s_axi_rresp !== e.resp || s_axi_rlast !== e.last || s_axi_rid !== id) begin
                        errors++;
                        $display("FAIL r_beat%0d got %h/%b/%b id=%b want %h/%b/%b id=%b", got, s_axi_rdata, s_axi_rresp,
                                 s_axi_rlast, s_axi_rid, e.data, e.resp, e.last, id);
                    end
                end
                got++;
            end else if (s_axi_rvalid) begin
                held = 1'b1; hd = s_axi_rdata; hr = s_axi_rresp; hl = s_axi_rlast;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_axi_rready = 1'b0;
        if (got < nbeats) begin checks++; errors++; $display("FAIL r_timeout got %0d beats want %0d", got, nbeats); end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic id, input bit toggle);
        push_read_exp(addr, len, size);
        ar_issue(addr, len, size, id);
        collect_r(id, int'(len) + 1, toggle);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        s_axi_awid = 1'b0; s_axi_awaddr = 32'h0; s_axi_awlen = 8'h0; s_axi_awsize = 3'd2; s_axi_awburst = 2'b01;
        s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0; s_axi_wlast = 1'b0;
        s_axi_arid = 1'b0; s_axi_araddr = 32'h0; s_axi_arlen = 8'h0; s_axi_arsize = 3'd2; s_axi_arburst = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, busy} !== 6'b0 ||
            s_axi_rdata !== 32'h0 || s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00 || s_axi_rlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got aw=%b ar=%b w=%b b=%b r=%b busy=%b rdata=%h want all 0",
                     s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, busy, s_axi_rdata);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready got aw=%b ar=%b busy=%b want 1 1 0", s_axi_awready, s_axi_arready, busy);
        end
    endtask

    task automatic test_single;
        axi_write(32'h40, 8'd0, 3'd2, 32'hDEADBEEF, 4'hF, 1'b1);
        axi_read(32'h40, 8'd0, 3'd2, 1'b1, 1'b0);
    endtask

    task automatic test_burst16;
        axi_write(32'h100, 8'd15, 3'd2, 32'h0, 4'hF, 1'b0);
        axi_read(32'h100, 8'd15, 3'd2, 1'b0, 1'b1);
    endtask

    task automatic test_strobe;
        axi_write(32'h20, 8'd0, 3'd2, 32'hFFFFFFFF, 4'hF, 1'b0);
        axi_write(32'h20, 8'd0, 3'd2, 32'h000000AA, 4'h1, 1'b0);
        axi_read(32'h20, 8'd0, 3'd2, 1'b0, 1'b0);
        checks++;
        if (model[8] !== 32'hFFFFFFAA) begin errors++; $display("FAIL strobe_model got %h want ffffffaa", model[8]); end
    endtask

    task automatic test_simultaneous;
        @(posedge clk); #1;
        s_axi_awid = 1'b1; s_axi_awaddr = 32'h80; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
        s_axi_arid = 1'b0; s_axi_araddr = 32'h80; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b0) begin
            errors++; $display("FAIL arb_idle got aw=%b ar=%b want 1 0", s_axi_awready, s_axi_arready);
        end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
        model[32] = 32'h12345678;
        @(negedge clk);
        checks++;
        if (s_axi_wready !== 1'b1 || s_axi_arready !== 1'b0) begin
            errors++; $display("FAIL arb_wdata got wready=%b ar=%b want 1 0", s_axi_wready, s_axi_arready);
        end
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || s_axi_bid !== 1'b1 || s_axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL arb_bresp got bvalid=%b bresp=%b bid=%b ar=%b want 1 00 1 0", s_axi_bvalid, s_axi_bresp, s_axi_bid, s_axi_arready);
        end
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        @(negedge clk);
        checks++;
        if (s_axi_arready !== 1'b1) begin errors++; $display("FAIL arb_after_b got arready=%b want 1", s_axi_arready); end
        push_read_exp(32'h80, 8'd0, 3'd2);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        collect_r(1'b0, 1, 1'b0);
    endtask

    task automatic test_boundary;
        axi_write(32'hFFC, 8'd0, 3'd2, 32'hCAFEF00D, 4'hF, 1'b1);
        axi_read(32'hFFC, 8'd1, 3'd2, 1'b0, 1'b0);
        axi_write(32'h20, 8'd0, 3'd1, 32'h11111111, 4'hF, 1'b0);
        axi_read(32'h20, 8'd0, 3'd2, 1'b1, 1'b0);
        axi_write(32'hFFC, 8'd1, 3'd2, 32'h0BAD0000, 4'hF, 1'b0);
        axi_read(32'hFFC, 8'd0, 3'd2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_burst;
        rexp_t e;
        axi_write(32'h200, 8'd7, 3'd2, 32'hA0000000, 4'hF, 1'b0);
        push_read_exp(32'h200, 8'd7, 3'd2);
        ar_issue(32'h200, 8'd7, 3'd2, 1'b1);
        s_axi_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = rq.pop_front();
            checks++;
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== e.data) begin
                errors++; $display("FAIL pre_reset_beat%0d got %b/%h want 1/%h", i, s_axi_rvalid, s_axi_rdata, e.data);
            end
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; s_axi_rready = 1'b0;
        rq.delete();
        @(negedge clk);
        checks++;
        if (s_axi_rvalid !== 1'b0 || busy !== 1'b0 || s_axi_arready !== 1'b1 || s_axi_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got rvalid=%b busy=%b arready=%b rdata=%h want 0 0 1 0", s_axi_rvalid, busy, s_axi_arready, s_axi_rdata);
        end
        axi_write(32'h204, 8'd0, 3'd2, 32'h55550001, 4'hF, 1'b1);
        axi_read(32'h200, 8'd3, 3'd2, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst16();
        test_strobe();
        test_simultaneous();
        test_boundary();
        test_reset_mid_burst();
        checks++;
        if (rq.size() != 0) begin errors++; $display("FAIL r_leftover got %0d want 0", rq.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
